// File: rtl/scenario_arbiter_pkg.sv
// Shared types for the scenario arbiter: FSM encoding, stimulus beat and a
// modulo-increment helper for the round-robin pointer.
package scenario_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int BEAT_DATA_W = 32;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic                   last;
  } beat_t;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/scenario_arbiter_if.sv
// Requester-side and DUT-side handshake bundle of the scenario arbiter.
// The master side is the stimulus environment; the slave side is the arbiter.
interface scenario_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] reqValid;
  logic [DATA_W-1:0]  reqData [NUM_REQ];
  logic [NUM_REQ-1:0] reqLast;
  logic [NUM_REQ-1:0] reqReady;
  logic               dutValid;
  logic [DATA_W-1:0]  dutData;
  logic               dutLast;
  logic               dutReady;
  logic               grantValid;
  logic [ID_W-1:0]    grantId;
  logic               overrun;

  modport master (
    output reqValid, reqData, reqLast, dutReady,
    input  reqReady, dutValid, dutData, dutLast, grantValid, grantId, overrun
  );

  modport slave (
    input  reqValid, reqData, reqLast, dutReady,
    output reqReady, dutValid, dutData, dutLast, grantValid, grantId, overrun
  );
endinterface

// File: rtl/scenario_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. Zero latency, no state.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any_req,
  output logic [ID_W-1:0]    winner
);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W:0]      offs;
  logic [ID_W:0]      sum;
  logic               found;

  always_comb begin
    // Doubling the vector turns the wrap-around scan into a plain low-first scan.
    rot   = NUM_REQ'({req, req} >> ptr);
    offs  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        offs  = (ID_W+1)'(i);
      end
    end
    sum = {1'b0, ptr} + offs;
    if (sum >= (ID_W+1)'(NUM_REQ)) begin
      sum = sum - (ID_W+1)'(NUM_REQ);
    end
    winner  = sum[ID_W-1:0];
    any_req = |req;
  end

endmodule

// File: rtl/scenario_arbiter.sv
// Round-robin arbiter granting the DUT stimulus port for one transaction at a time;
// grant one cycle after request, ready/valid pass straight through, one idle bubble per grant.
module scenario_arbiter
  import scenario_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  scenario_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               overrun_q, overrun_d;

  logic               any_req;
  logic [ID_W-1:0]    winner;
  logic               own_vld;
  logic               own_last;
  logic               at_max;
  logic               end_beat;
  logic               xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (bus.reqValid),
    .ptr     (rr_ptr_q),
    .any_req (any_req),
    .winner  (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    overrun_d  = overrun_q;

    own_vld  = bus.reqValid[grant_id_q];
    own_last = bus.reqLast[grant_id_q];
    at_max   = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
    end_beat = own_last | at_max;
    xfer     = 1'b0;

    bus.reqReady   = '0;
    bus.dutValid   = 1'b0;
    bus.dutData    = '0;
    bus.dutLast    = 1'b0;
    bus.grantValid = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = OWN;
          grant_id_d = winner;
          beat_cnt_d = '0;
        end
      end
      OWN: begin
        bus.grantValid = 1'b1;
        bus.dutValid   = own_vld;
        bus.dutData    = bus.reqData[grant_id_q];
        bus.dutLast    = end_beat;
        // Reset gates ready so an aborted transaction never loses a beat to the edge.
        bus.reqReady[grant_id_q] = bus.dutReady & ~rst;
        xfer = own_vld & bus.dutReady & ~rst;
        if (xfer) begin
          if (end_beat) begin
            state_d  = IDLE;
            rr_ptr_d = ID_W'(wrap_inc(int'(grant_id_q), NUM_REQ));
            if (!own_last) begin
              overrun_d = 1'b1;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grantId = grant_id_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_scenario_arbiter.sv
// Directed bench for scenario_arbiter: requester stream models feed the arbiter,
// a scoreboard of expected DUT-side beats is checked on every accepted beat.
module tb_scenario_arbiter;
  import scenario_arbiter_pkg::*;

  localparam int NR = 4;

  typedef struct {
    logic [31:0] dat;
    logic        lst;
    logic [1:0]  id;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scenario_arbiter_if #(.NUM_REQ(NR), .DATA_W(32)) bus ();

  scenario_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (32),
    .MAX_BEATS (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     errors = 0;
  int     checks = 0;
  int     cyc    = 0;
  exp_t   sb[$];
  int     xcyc[$];
  beat_t  src [NR][32];
  int     src_len [NR];
  int     src_idx [NR];
  logic [NR-1:0] acc = '0;
  logic [3:0]    bp_pat = 4'b1001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_idx[i] < src_len[i]) begin
        bus.reqValid[i] = 1'b1;
        bus.reqData[i]  = src[i][src_idx[i]].data;
        bus.reqLast[i]  = src[i][src_idx[i]].last;
      end else begin
        bus.reqValid[i] = 1'b0;
        bus.reqData[i]  = '0;
        bus.reqLast[i]  = 1'b0;
      end
    end
  endtask

  // mode 0: last on final beat, 1: last on every beat, 2: never last
  task automatic load(input int r, input int n, input logic [31:0] base, input int mode);
    for (int j = 0; j < n; j++) begin
      src[r][j].data = base + j;
      src[r][j].last = (mode == 1) || (mode == 0 && j == n - 1);
    end
    src_len[r] = n;
    src_idx[r] = 0;
    drive();
  endtask

  task automatic push(input int id, input logic [31:0] dat, input logic lst);
    exp_t e;
    e.dat = dat;
    e.lst = lst;
    e.id  = 2'(id);
    sb.push_back(e);
  endtask

  function automatic bit sources_empty();
    for (int i = 0; i < NR; i++) begin
      if (src_idx[i] < src_len[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) src_idx[i]++;
    end
    drive();
  endtask

  task automatic wait_done(input int budget, input bit bp);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      if (bp) bus.dutReady = bp_pat[k % 4];
      done = sources_empty() && (sb.size() == 0);
      @(negedge clk);
      if (bp && bus.dutValid && !bus.dutReady && sb.size() > 0)
        chk("bp_hold", bus.dutData, sb[0].dat);
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  // Monitor: every requester-side acceptance must match the next expected beat.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    acc = bus.reqValid & bus.reqReady;
    if (|acc) begin
      xcyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'(acc), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("beat_acc", 32'(acc), 32'(4'b0001 << e.id));
        chk("beat_vld", 32'(bus.dutValid), 32'd1);
        chk("beat_dat", bus.dutData, e.dat);
        chk("beat_last", 32'(bus.dutLast), 32'(e.lst));
        chk("beat_id", 32'(bus.grantId), 32'(e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.dutReady = 1'b0;
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_idx[i] = 0;
    end
    drive();
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.reqReady), 32'd0);
    chk("rst_dut_vld", 32'(bus.dutValid), 32'd0);
    chk("rst_dut_last", 32'(bus.dutLast), 32'd0);
    chk("rst_grant_vld", 32'(bus.grantValid), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_grant_id", 32'(bus.grantId), 32'd0);

    // Move rrPtr to 2 so the post-reset pick below proves the pointer was cleared.
    tick();
    bus.dutReady = 1'b1;
    load(1, 1, 32'h100, 0);
    push(1, 32'h100, 1'b1);
    wait_done(20, 1'b0);

    // Reset mid-grant: requester 2 three beats into a five-beat transaction.
    tick();
    load(2, 5, 32'h200, 0);
    for (int j = 0; j < 3; j++) push(2, 32'h200 + j, 1'b0);
    for (int k = 0; k < 20 && src_idx[2] != 3; k++) tick();
    chk("mid_beats", 32'(src_idx[2]), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(bus.reqReady), 32'd0);
    tick();
    rst = 1'b0;
    src_len[2] = 0;
    drive();
    @(negedge clk);
    chk("mid_grant_vld", 32'(bus.grantValid), 32'd0);
    chk("mid_overrun", 32'(bus.overrun), 32'd0);
    tick();
    load(3, 1, 32'h300, 0);
    load(0, 1, 32'h0a0, 0);
    push(0, 32'h0a0, 1'b1);
    push(3, 32'h300, 1'b1);
    wait_done(20, 1'b0);

    // Round-robin fairness with single-beat transactions.
    tick();
    xcyc.delete();
    for (int i = 0; i < NR; i++) load(i, 2, 32'h400 + 16 * i, 1);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) push(i, 32'h400 + 16 * i + r, 1'b1);
    wait_done(60, 1'b0);
    chk("rr_count", 32'(xcyc.size()), 32'd8);
    if (xcyc.size() >= 8) chk("rr_span", 32'(xcyc[7] - xcyc[0]), 32'd14);

    // Wrap and skip: rrPtr at 3 with requesters 1 and 3 pending.
    tick();
    load(2, 1, 32'h500, 0);
    push(2, 32'h500, 1'b1);
    wait_done(20, 1'b0);
    tick();
    load(1, 1, 32'h510, 0);
    load(3, 1, 32'h530, 0);
    push(3, 32'h530, 1'b1);
    push(1, 32'h510, 1'b1);
    wait_done(20, 1'b0);

    // Backpressure on a four-beat transaction.
    tick();
    load(1, 4, 32'h600, 0);
    for (int j = 0; j < 4; j++) push(1, 32'h600 + j, j == 3);
    wait_done(40, 1'b1);
    chk("bp_grant_end", 32'(bus.grantValid), 32'd0);
    chk("bp_overrun", 32'(bus.overrun), 32'd0);

    // Forced release at 16 beats; requester 2 waiting wins the next pick.
    tick();
    bus.dutReady = 1'b1;
    load(0, 20, 32'h700, 2);
    for (int j = 0; j < 16; j++) push(0, 32'h700 + j, j == 15);
    for (int k = 0; k < 10 && !bus.grantValid; k++) tick();
    chk("fr_grant", 32'(bus.grantValid), 32'd1);
    load(2, 1, 32'h7f0, 0);
    push(2, 32'h7f0, 1'b1);
    for (int j = 16; j < 20; j++) push(0, 32'h700 + j, 1'b0);
    wait_done(80, 1'b0);
    chk("fr_overrun", 32'(bus.overrun), 32'd1);
    chk("fr_held", 32'(bus.grantValid), 32'd1);
    chk("fr_held_id", 32'(bus.grantId), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("fr_overrun_clr", 32'(bus.overrun), 32'd0);

    // Requester 3 arrives in the cycle requester 0's last beat transfers.
    tick();
    load(0, 2, 32'h800, 1);
    push(0, 32'h800, 1'b1);
    for (int k = 0; k < 10 && !bus.grantValid; k++) tick();
    chk("sim_grant", 32'(bus.grantValid), 32'd1);
    load(3, 1, 32'h830, 0);
    push(3, 32'h830, 1'b1);
    push(0, 32'h801, 1'b1);
    wait_done(30, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
